// File: rtl/instr_fetch_responder_pkg.sv
// Shared widths and FIFO sizing for the instruction-fetch responder.
// Optional feature macro: INSTR_FETCH_RANGE_CHK_EN adds an error bit to every FIFO entry.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef FETCH_ADDR_WIDTH
`define FETCH_ADDR_WIDTH 8
`endif
`ifndef FETCH_FIFO_DEPTH
`define FETCH_FIFO_DEPTH 2
`endif

package instr_fetch_responder_pkg;

    localparam int FIFO_DEPTH = `FETCH_FIFO_DEPTH;

    typedef logic [1:0] fifo_cnt_t;

`ifdef INSTR_FETCH_RANGE_CHK_EN
    localparam int ERR_W = 1;
`else
    localparam int ERR_W = 0;
`endif

    function automatic int entry_width(input int dw, input int aw);
        return dw + aw + ERR_W;
    endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request, memory read and response channels of the fetch responder.
// Optional feature macro: INSTR_FETCH_RANGE_CHK_EN adds rsp_err.
interface instr_fetch_responder_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `FETCH_ADDR_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  flush;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_addr;
`ifdef INSTR_FETCH_RANGE_CHK_EN
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
    modport master (
        output req_valid, req_addr, flush, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_addr, rsp_err
    );
`else
    modport slave (
        input  req_valid, req_addr, flush, mem_rdata, rsp_ready,
        output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_addr
    );
    modport master (
        output req_valid, req_addr, flush, mem_rdata, rsp_ready,
        input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_addr
    );
`endif
endinterface

// File: rtl/instr_fetch_responder_fetch_rsp_fifo.sv
// Two-entry response FIFO with registered head outputs; clear beats push and pop.
// Latency: push visible at head the next cycle; pushes into a full FIFO without a pop are ignored.
module fetch_rsp_fifo
    import instr_fetch_responder_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output fifo_cnt_t    count_o,
    output logic         head_vld_o,
    output logic [W-1:0] head_dat_o
);
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    fifo_cnt_t    cnt_q;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop_i && (cnt_q != 2'd0);
    assign push_ok = push_i && ((cnt_q < 2'(FIFO_DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= push_dat_i;
                    else               tail_q <= push_dat_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new entry lands behind whatever remains.
                    if (cnt_q == 2'd1) begin
                        head_q <= push_dat_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o    = cnt_q;
    assign head_vld_o = (cnt_q != 2'd0);
    assign head_dat_o = head_q;
endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: PC requests -> sync instruction memory -> buffered responses.
// Latency 2 cycles accept-to-response; ready drops when 2 entries are committed and no pop.
// Optional feature macro: INSTR_FETCH_RANGE_CHK_EN (out-of-range fetches return err, no memory read).
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `FETCH_ADDR_WIDTH,
    parameter int MEM_DEPTH  = 192
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_responder_if.slave bus
);
    localparam int ENTRY_W = entry_width(DATA_WIDTH, ADDR_WIDTH);

    if (MEM_DEPTH < 1) begin : g_bad_depth
        $error("MEM_DEPTH must be positive");
    end

    logic                  inflight_q, inflight_d;
    logic                  dropped_q,  dropped_d;
    logic [ADDR_WIDTH-1:0] infl_addr_q, infl_addr_d;
    fifo_cnt_t             fifo_count;
    logic                  fifo_vld;
    logic [ENTRY_W-1:0]    head_dat;
    logic [ENTRY_W-1:0]    push_dat;
    logic                  occ_low, pop, accept, push, in_range, req_ready;

    assign pop       = fifo_vld && bus.rsp_ready;
    assign occ_low   = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;
    assign req_ready = !rst && !bus.flush && (occ_low || pop);
    assign accept    = bus.req_valid && req_ready;
    assign push      = inflight_q && !dropped_q && !bus.flush;

    always_comb begin
        inflight_d  = accept;
        dropped_d   = bus.flush && inflight_q;
        infl_addr_d = accept ? bus.req_addr : infl_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            dropped_q   <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            dropped_q   <= dropped_d;
            infl_addr_q <= infl_addr_d;
        end
    end

`ifdef INSTR_FETCH_RANGE_CHK_EN
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);
    logic                  infl_err_q;
    logic [DATA_WIDTH-1:0] rdata_eff;

    assign in_range  = {{(32-ADDR_WIDTH){1'b0}}, bus.req_addr} < MEM_LIMIT;
    assign rdata_eff = infl_err_q ? {DATA_WIDTH{1'b0}} : bus.mem_rdata;
    assign push_dat  = {infl_err_q, infl_addr_q, rdata_eff};
    assign bus.rsp_err = head_dat[ENTRY_W-1];

    always_ff @(posedge clk) begin
        if (rst)         infl_err_q <= 1'b0;
        else if (accept) infl_err_q <= !in_range;
    end
`else
    assign in_range = 1'b1;
    assign push_dat = {infl_addr_q, bus.mem_rdata};
`endif

    fetch_rsp_fifo #(.W(ENTRY_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.flush),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .count_o    (fifo_count),
        .head_vld_o (fifo_vld),
        .head_dat_o (head_dat)
    );

    assign bus.req_ready = req_ready;
    assign bus.mem_rd_en = accept && in_range;
    assign bus.mem_addr  = bus.req_addr;
    assign bus.rsp_valid = fifo_vld;
    assign bus.rsp_data  = head_dat[DATA_WIDTH-1:0];
    assign bus.rsp_addr  = head_dat[DATA_WIDTH +: ADDR_WIDTH];
endmodule
